// File: rtl/n_serial_subtractor.sv
// n_serial_subtractor: bit-serial N-bit two's-complement subtractor (D = A - B - bi), LSB first; macro SERIAL_SUB_ADD_MODE_EN adds an op port selecting A + B + bi
module n_serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         bi,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic         op,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         bo,
  output logic         ovf
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, s_q, s_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic br_q, br_d, bo_q, bo_d, ovf_q, ovf_d, add_q, add_d;
  logic bit_d, br_nx, last;
  // serial datapath and next-state: one difference bit per RUN edge, results published only on completion
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    d_d = d_q;
    cnt_d = cnt_q;
    br_d = br_q;
    bo_d = bo_q;
    ovf_d = ovf_q;
    add_d = add_q;
    bit_d = a_q[0] ^ b_q[0] ^ br_q;
    br_nx = add_q ? ((a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & br_q))
                  : ((~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q));
    last = cnt_q == CW'(N - 1);
    if (start && state_q != RUN) begin
      state_d = RUN;
      a_d = A;
      b_d = B;
      br_d = bi;
      s_d = '0;
      cnt_d = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      add_d = op;
`else
      add_d = 1'b0;
`endif
    end else if (state_q == RUN) begin
      s_d = {bit_d, s_q[N-1:1]};
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      br_d = br_nx;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        state_d = FIN;
        d_d = {bit_d, s_q[N-1:1]};
        bo_d = br_nx;
        ovf_d = br_q ^ br_nx;
      end
    end else if (state_q == FIN) begin
      state_d = IDLE;
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      br_q <= 1'b0;
      bo_q <= 1'b0;
      ovf_q <= 1'b0;
      add_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      br_q <= br_d;
      bo_q <= bo_d;
      ovf_q <= ovf_d;
      add_q <= add_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == FIN;
  assign D = d_q;
  assign bo = bo_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_n_serial_subtractor.sv
// tb_n_serial_subtractor: randomized and directed self-checking bench against an arithmetic reference model
module tb_n_serial_subtractor;
  localparam int N = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bi = 1'b0, op = 1'b0;
  logic [N-1:0] A = '0, B = '0;
  logic busy, done, bo, ovf;
  logic [N-1:0] D;
  int checks = 0, errs = 0;

  n_serial_subtractor #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .bi(bi),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .op(op),
`endif
    .busy(busy), .done(done), .D(D), .bo(bo), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic o);
    logic [N:0] s;
    int si;
    s = o ? ({1'b0, a} + {1'b0, b} + (N+1)'(c)) : ({1'b0, a} - {1'b0, b} - (N+1)'(c));
    si = o ? ($signed(a) + $signed(b) + int'(c)) : ($signed(a) - $signed(b) - int'(c));
    return {(si > 127 || si < -128), s};
  endfunction

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic o);
    @(negedge clk);
    A = a; B = b; bi = c; op = o; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < N + 6) begin
      @(posedge clk);
      #1 k++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({busy, done, bo, ovf, D} !== '0) begin errs++; $display("FAIL reset_hold got %b expected 0", {busy, done, bo, ovf, D}); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done, bo, ovf, D} !== '0) begin errs++; $display("FAIL reset_release got %b expected 0", {busy, done, bo, ovf, D}); end
  endtask

  task automatic test_directed;
    logic [N-1:0] ta [6] = '{8'd5, 8'd30, 8'h80, 8'd127, 8'd5, 8'd3};
    logic [N-1:0] tb [6] = '{8'd10, 8'hF6, 8'd1, 8'hFF, 8'd10, 8'd3};
    logic tc [6] = '{0, 0, 0, 0, 1, 0};
    logic [N+1:0] te [6] = '{{2'b01, 8'hFB}, {2'b01, 8'h28}, {2'b10, 8'h7F}, {2'b11, 8'h80}, {2'b01, 8'hFA}, {2'b00, 8'h00}};
    int k;
    for (int i = 0; i < 6; i++) begin
      launch(ta[i], tb[i], tc[i], 1'b0);
      checks++;
      if (busy !== 1'b1) begin errs++; $display("FAIL dir%0d_busy got %b expected 1", i, busy); end
      wait_done(k);
      checks++;
      if (k !== N) begin errs++; $display("FAIL dir%0d_latency got %0d expected %0d", i, k, N); end
      checks++;
      if ({ovf, bo, D} !== te[i] || busy !== 1'b0) begin errs++; $display("FAIL dir%0d_result got ovf,bo,D=%b busy=%b expected %b", i, {ovf, bo, D}, busy, te[i]); end
    end
    repeat (3) @(posedge clk);
    #1 checks++;
    if ({ovf, bo, D} !== te[5] || done !== 1'b0) begin errs++; $display("FAIL hold got %b done=%b expected %b", {ovf, bo, D}, done, te[5]); end
  endtask

  task automatic test_ignore;
    int pulses = 0;
    launch(8'd5, 8'd10, 1'b1, 1'b0);
    @(negedge clk);
    A = 8'd99; B = 8'd1; bi = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 2 * N + 4; i++) begin
      @(posedge clk);
      #1 if (done) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errs++; $display("FAIL ignore_done_count got %0d expected 1", pulses); end
    checks++;
    if ({bo, D} !== {1'b1, 8'hFA}) begin errs++; $display("FAIL ignore_result got %b expected %b", {bo, D}, {1'b1, 8'hFA}); end
  endtask

  task automatic test_back_to_back;
    int k;
    logic [N+1:0] e1, e2;
    e1 = model(8'd100, 8'd7, 1'b0, 1'b0);
    e2 = model(8'd7, 8'd100, 1'b1, 1'b0);
    @(negedge clk);
    A = 8'd100; B = 8'd7; bi = 1'b0; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 A = 8'd7; B = 8'd100; bi = 1'b1;
    wait_done(k);
    checks++;
    if (k !== N || {ovf, bo, D} !== e1) begin errs++; $display("FAIL b2b_first got lat=%0d %b expected lat=%0d %b", k, {ovf, bo, D}, N, e1); end
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errs++; $display("FAIL b2b_accept got busy=%b expected 1", busy); end
    wait_done(k);
    checks++;
    if (k !== N || {ovf, bo, D} !== e2) begin errs++; $display("FAIL b2b_second got lat=%0d %b expected lat=%0d %b", k, {ovf, bo, D}, N, e2); end
  endtask

  task automatic test_async_reset;
    int k;
    launch(8'd77, 8'd12, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 checks++;
    if ({busy, done, bo, ovf, D} !== '0) begin errs++; $display("FAIL async_reset got %b expected 0", {busy, done, bo, ovf, D}); end
    @(negedge clk) rst = 1'b0;
    launch(8'd3, 8'd3, 1'b0, 1'b0);
    wait_done(k);
    checks++;
    if (k !== N || {ovf, bo, D} !== '0) begin errs++; $display("FAIL after_reset got lat=%0d %b expected lat=%0d 0", k, {ovf, bo, D}, N); end
  endtask

  task automatic test_random(input logic o);
    int k;
    logic [N-1:0] a, b;
    logic c;
    logic [N+1:0] e;
    for (int i = 0; i < 10; i++) begin
      a = N'($urandom); b = N'($urandom); c = 1'($urandom % 2);
      e = model(a, b, c, o);
      launch(a, b, c, o);
      @(negedge clk);
      A = N'($urandom); B = N'($urandom); bi = ~c;
      wait_done(k);
      checks++;
      if (k > N || {ovf, bo, D} !== e) begin errs++; $display("FAIL rand_op%0d_%0d a=%h b=%h c=%b got %b expected %b", o, i, a, b, c, {ovf, bo, D}, e); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_ignore;
    test_back_to_back;
    test_async_reset;
    test_random(1'b0);
`ifdef SERIAL_SUB_ADD_MODE_EN
    test_random(1'b1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
